// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - memory-side arbiter serializing icache/dcache requests onto a single-ported RAM
//
// Purpose:
//   Accepts instruction-fetch and data read/write requests, grants one at a
//   time to the RAM, and returns data plus a one-cycle wait-low pulse to the
//   granted requester. Any access that sees RAM ERROR, or that stays
//   outstanding until the cycle counter reaches TIMEOUT, is aborted. An abort
//   returns load data of 0 and sets the sticky bus_err flag.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   iREN, iaddr              instruction read request and word address
//   dREN, dWEN, daddr,       data read/write request, address and store value
//   dstore                   (write wins if dREN and dWEN are both high)
//   iwait, iload             instruction wait (low one cycle) and returned word
//   dwait, dload             data wait (low one cycle) and returned word
//   ramREN, ramWEN,          registered RAM command
//   ramaddr, ramstore
//   ramload, ramstate        RAM read data, RAM status (FREE/BUSY/ACCESS/ERROR)
//   bus_err                  sticky abort flag, cleared only by RST
//
// Configuration:
//   ARB_RR_EN  when defined, simultaneous requests are resolved round-robin.
//              When undefined, data always beats instruction.

module cache_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [7:0] TO_CNT     = TIMEOUT[7:0];

  state_t     state;
  logic [7:0] cnt;
  logic       ram_access;
  logic       abort;
  logic       d_req;
  logic       grant_d;
  logic       grant_i;

  assign ram_access = (ramstate == RAM_ACCESS);
  // A completing ACCESS takes precedence over a timeout in the same cycle.
  assign abort      = !ram_access && ((ramstate == RAM_ERROR) || (cnt == TO_CNT));
  assign d_req      = dREN | dWEN;

`ifdef ARB_RR_EN
  // last_d remembers who was served last; on a tie the other side wins.
  logic last_d;
  assign grant_d = d_req && !(iREN && last_d);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = iREN && !grant_d;

  // Wait/load outputs follow state and ramstate directly. They are held
  // inactive while RST is high so that a reset mid-access never leaks a pulse.
  always_comb begin
    iwait = 1'b1;
    dwait = 1'b1;
    iload = 32'd0;
    dload = 32'd0;
    if (!RST) begin
      case (state)
        IACC: begin
          if (ram_access) begin
            iwait = 1'b0;
            iload = ramload;
          end else if (abort) begin
            iwait = 1'b0;
          end
        end
        DACC: begin
          if (ram_access) begin
            dwait = 1'b0;
            dload = ramload;
          end else if (abort) begin
            dwait = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= 32'd0;
      ramstore <= 32'd0;
      bus_err  <= 1'b0;
`ifdef ARB_RR_EN
      last_d   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          // The RAM command registers double as the latched request.
          if (grant_d) begin
            state    <= DACC;
            ramREN   <= !dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
          end else if (grant_i) begin
            state    <= IACC;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= iaddr;
            ramstore <= 32'd0;
          end
        end
        IACC, DACC: begin
          if (ram_access || abort) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= 32'd0;
            ramstore <= 32'd0;
            if (abort)
              bus_err <= 1'b1;
`ifdef ARB_RR_EN
            last_d <= (state == DACC);
`endif
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
